// File: rtl/mem_request_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mem_request_buffer
// Brief    : Serial-tagging request queue between the core memory port and a
//            valid/ready memory backend, with in-order read data return.
// Revision : 1.0
// ============================================================================
module mem_request_buffer #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 128,
    parameter int SERIAL_WIDTH = 4,
    parameter int REQ_DEPTH    = 4,
    parameter int MAX_READS    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   memAccessAddr,
    input  logic [DATA_WIDTH-1:0]   memAccessWriteData,
    input  logic                    memAccessRE,
    input  logic                    memAccessWE,
    output logic                    memAccessReadBusy,
    output logic                    memAccessWriteBusy,
    output logic [SERIAL_WIDTH-1:0] nextMemReadSerial,
    output logic [SERIAL_WIDTH-1:0] nextMemWriteSerial,
    output logic                    memReadDataReady,
    output logic [DATA_WIDTH-1:0]   memReadData,
    output logic [SERIAL_WIDTH-1:0] memReadSerial,
    output logic                    memAccessResponseValid,
    output logic [SERIAL_WIDTH-1:0] memAccessResponseSerial,
    output logic                    backendReqValid,
    input  logic                    backendReqReady,
    output logic                    backendReqWE,
    output logic [ADDR_WIDTH-1:0]   backendReqAddr,
    output logic [DATA_WIDTH-1:0]   backendReqWData,
    input  logic                    backendRspValid,
    input  logic [DATA_WIDTH-1:0]   backendRspData,
    output logic                    protocolError
);

    localparam int c_PTR_W  = $clog2(REQ_DEPTH);
    localparam int c_CNT_W  = $clog2(REQ_DEPTH + 1);
    localparam int c_TAG_IW = (MAX_READS > 1) ? $clog2(MAX_READS) : 1;
    localparam int c_RD_W   = $clog2(MAX_READS + 1);
    localparam logic [c_CNT_W-1:0]  c_REQ_FULL = c_CNT_W'(REQ_DEPTH);
    localparam logic [c_RD_W-1:0]   c_RD_FULL  = c_RD_W'(MAX_READS);
    localparam logic [c_TAG_IW-1:0] c_TAG_LAST = c_TAG_IW'(MAX_READS - 1);

    logic                    r_reqWe     [REQ_DEPTH];
    logic [ADDR_WIDTH-1:0]   r_reqAddr   [REQ_DEPTH];
    logic [DATA_WIDTH-1:0]   r_reqData   [REQ_DEPTH];
    logic [SERIAL_WIDTH-1:0] r_reqSerial [REQ_DEPTH];
    logic [c_PTR_W-1:0]      r_reqWrPtr, r_reqRdPtr;
    logic [c_CNT_W-1:0]      r_reqCount;

    logic [SERIAL_WIDTH-1:0] r_tagMem [MAX_READS];
    logic [c_TAG_IW-1:0]     r_tagWrPtr, r_tagRdPtr;
    logic [c_RD_W-1:0]       r_tagCount;

    logic [c_RD_W-1:0]       r_readInflight;
    logic [SERIAL_WIDTH-1:0] r_nextReadSerial, r_nextWriteSerial;
    logic                    r_rdValid, r_wrRspValid, r_protocolError;
    logic [DATA_WIDTH-1:0]   r_rdData;
    logic [SERIAL_WIDTH-1:0] r_rdSerial, r_wrRspSerial;

    logic w_reqFull, w_reqEmpty, w_readBusy, w_writeBusy;
    logic w_wrAccept, w_rdAccept, w_push, w_pop, w_popRead, w_popWrite;
    logic w_tagEmpty, w_tagPop, w_violation;

    assign w_reqFull   = (r_reqCount == c_REQ_FULL);
    assign w_reqEmpty  = (r_reqCount == '0);
    assign w_writeBusy = w_reqFull;
    assign w_readBusy  = w_reqFull | (r_readInflight == c_RD_FULL);

    // A simultaneous write wins; the colliding read is dropped and flagged.
    assign w_wrAccept = memAccessWE & ~w_writeBusy;
    assign w_rdAccept = memAccessRE & ~memAccessWE & ~w_readBusy;
    assign w_push     = w_wrAccept | w_rdAccept;
    assign w_pop      = ~w_reqEmpty & backendReqReady;
    assign w_popRead  = w_pop & ~r_reqWe[r_reqRdPtr];
    assign w_popWrite = w_pop & r_reqWe[r_reqRdPtr];

    assign w_tagEmpty = (r_tagCount == '0);
    assign w_tagPop   = backendRspValid & ~w_tagEmpty;

    assign w_violation = (memAccessRE & memAccessWE) | (memAccessRE & w_readBusy) |
                         (memAccessWE & w_writeBusy) | (backendRspValid & w_tagEmpty);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_reqWe[r_reqWrPtr]     <= w_wrAccept;
            r_reqAddr[r_reqWrPtr]   <= memAccessAddr;
            r_reqData[r_reqWrPtr]   <= w_wrAccept ? memAccessWriteData : '0;
            r_reqSerial[r_reqWrPtr] <= w_wrAccept ? r_nextWriteSerial : r_nextReadSerial;
        end
        if (w_popRead) begin
            r_tagMem[r_tagWrPtr] <= r_reqSerial[r_reqRdPtr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reqWrPtr        <= '0;
            r_reqRdPtr        <= '0;
            r_reqCount        <= '0;
            r_tagWrPtr        <= '0;
            r_tagRdPtr        <= '0;
            r_tagCount        <= '0;
            r_readInflight    <= '0;
            r_nextReadSerial  <= '0;
            r_nextWriteSerial <= '0;
            r_rdValid         <= 1'b0;
            r_rdData          <= '0;
            r_rdSerial        <= '0;
            r_wrRspValid      <= 1'b0;
            r_wrRspSerial     <= '0;
            r_protocolError   <= 1'b0;
        end else begin
            if (w_push) r_reqWrPtr <= r_reqWrPtr + c_PTR_W'(1);
            if (w_pop)  r_reqRdPtr <= r_reqRdPtr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_reqCount <= r_reqCount + c_CNT_W'(1);
                2'b01:   r_reqCount <= r_reqCount - c_CNT_W'(1);
                default: r_reqCount <= r_reqCount;
            endcase

            if (w_popRead) r_tagWrPtr <= (r_tagWrPtr == c_TAG_LAST) ? '0 : r_tagWrPtr + c_TAG_IW'(1);
            if (w_tagPop)  r_tagRdPtr <= (r_tagRdPtr == c_TAG_LAST) ? '0 : r_tagRdPtr + c_TAG_IW'(1);
            case ({w_popRead, w_tagPop})
                2'b10:   r_tagCount <= r_tagCount + c_RD_W'(1);
                2'b01:   r_tagCount <= r_tagCount - c_RD_W'(1);
                default: r_tagCount <= r_tagCount;
            endcase

            // A read stays in flight until its data pulse has been presented.
            case ({w_rdAccept, r_rdValid})
                2'b10:   r_readInflight <= r_readInflight + c_RD_W'(1);
                2'b01:   r_readInflight <= r_readInflight - c_RD_W'(1);
                default: r_readInflight <= r_readInflight;
            endcase

            if (w_rdAccept) r_nextReadSerial  <= r_nextReadSerial + SERIAL_WIDTH'(1);
            if (w_wrAccept) r_nextWriteSerial <= r_nextWriteSerial + SERIAL_WIDTH'(1);

            r_rdValid <= w_tagPop;
            if (w_tagPop) begin
                r_rdData   <= backendRspData;
                r_rdSerial <= r_tagMem[r_tagRdPtr];
            end

            r_wrRspValid <= w_popWrite;
            if (w_popWrite) r_wrRspSerial <= r_reqSerial[r_reqRdPtr];

            if (w_violation) r_protocolError <= 1'b1;
        end
    end

    assign memAccessWriteBusy      = w_writeBusy;
    assign memAccessReadBusy       = w_readBusy;
    assign nextMemReadSerial       = r_nextReadSerial;
    assign nextMemWriteSerial      = r_nextWriteSerial;
    assign memReadDataReady        = r_rdValid;
    assign memReadData             = r_rdData;
    assign memReadSerial           = r_rdSerial;
    assign memAccessResponseValid  = r_wrRspValid;
    assign memAccessResponseSerial = r_wrRspSerial;
    assign protocolError           = r_protocolError;

    // Payload is masked while empty so unreset storage never reaches the pins.
    assign backendReqValid = ~w_reqEmpty;
    assign backendReqWE    = ~w_reqEmpty & r_reqWe[r_reqRdPtr];
    assign backendReqAddr  = w_reqEmpty ? '0 : r_reqAddr[r_reqRdPtr];
    assign backendReqWData = w_reqEmpty ? '0 : r_reqData[r_reqRdPtr];

endmodule
`default_nettype wire

// File: tb/tb_mem_request_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_request_buffer
// Brief    : Scoreboard bench for mem_request_buffer with a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_mem_request_buffer;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int SW = 4;
    localparam int RQ = 4;
    localparam int MR = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] memAccessAddr = '0;
    logic [DW-1:0] memAccessWriteData = '0;
    logic          memAccessRE = 1'b0, memAccessWE = 1'b0;
    logic          memAccessReadBusy, memAccessWriteBusy;
    logic [SW-1:0] nextMemReadSerial, nextMemWriteSerial;
    logic          memReadDataReady;
    logic [DW-1:0] memReadData;
    logic [SW-1:0] memReadSerial;
    logic          memAccessResponseValid;
    logic [SW-1:0] memAccessResponseSerial;
    logic          backendReqValid;
    logic          backendReqReady = 1'b0;
    logic          backendReqWE;
    logic [AW-1:0] backendReqAddr;
    logic [DW-1:0] backendReqWData;
    logic          backendRspValid = 1'b0;
    logic [DW-1:0] backendRspData = '0;
    logic          protocolError;

    mem_request_buffer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SERIAL_WIDTH(SW), .REQ_DEPTH(RQ), .MAX_READS(MR)
    ) dut (
        .clk(clk), .rst(rst),
        .memAccessAddr(memAccessAddr), .memAccessWriteData(memAccessWriteData),
        .memAccessRE(memAccessRE), .memAccessWE(memAccessWE),
        .memAccessReadBusy(memAccessReadBusy), .memAccessWriteBusy(memAccessWriteBusy),
        .nextMemReadSerial(nextMemReadSerial), .nextMemWriteSerial(nextMemWriteSerial),
        .memReadDataReady(memReadDataReady), .memReadData(memReadData),
        .memReadSerial(memReadSerial),
        .memAccessResponseValid(memAccessResponseValid),
        .memAccessResponseSerial(memAccessResponseSerial),
        .backendReqValid(backendReqValid), .backendReqReady(backendReqReady),
        .backendReqWE(backendReqWE), .backendReqAddr(backendReqAddr),
        .backendReqWData(backendReqWData),
        .backendRspValid(backendRspValid), .backendRspData(backendRspData),
        .protocolError(protocolError)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] serial;
    } req_t;
    typedef struct {
        logic [SW-1:0] serial;
        logic [DW-1:0] data;
    } rsp_t;

    // Reference model: plain queues describing what the buffer holds.
    req_t          reqQ[$];
    logic [SW-1:0] tagQ[$];
    rsp_t          rdExpQ[$];
    logic [SW-1:0] wrExpQ[$];
    int            mRdInflight = 0;
    logic [SW-1:0] mNextRd = '0, mNextWr = '0;
    bit            mErr = 1'b0, mDecPending = 1'b0;

    int nCompared = 0;
    int nMismatched = 0;

    logic [1:0] readyMode = 2'd1;
    bit         rspEn = 1'b0;
    int         rspPct = 100;

    function automatic bit mBusyW();
        return reqQ.size() == RQ;
    endfunction

    function automatic bit mBusyR();
        return (reqQ.size() == RQ) || (mRdInflight == MR);
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each active edge, using pre-edge model state.
    req_t          mHead;
    rsp_t          mRsp;
    bit            mBW, mBR, mDec;
    initial forever begin
        @(posedge clk);
        if (rst) begin
            reqQ.delete(); tagQ.delete(); rdExpQ.delete(); wrExpQ.delete();
            mRdInflight = 0; mNextRd = '0; mNextWr = '0; mErr = 1'b0; mDecPending = 1'b0;
        end else begin
            mBW = mBusyW();
            mBR = mBusyR();
            mDec = mDecPending;
            mDecPending = 1'b0;
            if (backendRspValid) begin
                if (tagQ.size() > 0) begin
                    mRsp.serial = tagQ.pop_front();
                    mRsp.data   = backendRspData;
                    rdExpQ.push_back(mRsp);
                    mDecPending = 1'b1;
                end else begin
                    mErr = 1'b1;
                end
            end
            if (reqQ.size() > 0 && backendReqReady) begin
                mHead = reqQ.pop_front();
                if (mHead.we) wrExpQ.push_back(mHead.serial);
                else          tagQ.push_back(mHead.serial);
            end
            if (mDec) mRdInflight--;
            if (memAccessWE) begin
                if (mBW) mErr = 1'b1;
                else begin
                    mHead.we = 1'b1; mHead.addr = memAccessAddr;
                    mHead.data = memAccessWriteData; mHead.serial = mNextWr;
                    reqQ.push_back(mHead);
                    mNextWr++;
                end
            end
            if (memAccessRE) begin
                if (memAccessWE || mBR) mErr = 1'b1;
                else begin
                    mHead.we = 1'b0; mHead.addr = memAccessAddr;
                    mHead.data = '0; mHead.serial = mNextRd;
                    reqQ.push_back(mHead);
                    mNextRd++;
                    mRdInflight++;
                end
            end
        end
    end

    // Monitor: compares DUT outputs with the model between active edges.
    rsp_t          monRd;
    logic [SW-1:0] monWr;
    initial forever begin
        @(negedge clk);
        chk("writeBusy", memAccessWriteBusy, mBusyW());
        chk("readBusy", memAccessReadBusy, mBusyR());
        chk("nextRdSerial", nextMemReadSerial, mNextRd);
        chk("nextWrSerial", nextMemWriteSerial, mNextWr);
        chk("protocolError", protocolError, mErr);
        chk("reqValid", backendReqValid, reqQ.size() > 0);
        if (reqQ.size() > 0) begin
            chk("reqWE", backendReqWE, reqQ[0].we);
            chk("reqAddr", backendReqAddr, reqQ[0].addr);
            if (reqQ[0].we) chk("reqWData", backendReqWData, reqQ[0].data);
        end
        chk("rdReady", memReadDataReady, rdExpQ.size() > 0);
        if (rdExpQ.size() > 0) begin
            monRd = rdExpQ.pop_front();
            if (memReadDataReady) begin
                chk("rdSerial", memReadSerial, monRd.serial);
                chk("rdData", memReadData, monRd.data);
            end
        end
        chk("wrRspValid", memAccessResponseValid, wrExpQ.size() > 0);
        if (wrExpQ.size() > 0) begin
            monWr = wrExpQ.pop_front();
            if (memAccessResponseValid) chk("wrRspSerial", memAccessResponseSerial, monWr);
        end
    end

    // One clock of stimulus; entered and left just after a falling edge.
    task automatic step(input bit re, input bit we, input logic [AW-1:0] a, input bit forceRsp);
        memAccessRE        = re;
        memAccessWE        = we;
        memAccessAddr      = a;
        memAccessWriteData = {$urandom(), $urandom(), $urandom(), $urandom()};
        backendReqReady    = (readyMode == 2'd1) ? 1'b1 :
                             (readyMode == 2'd2) ? 1'($urandom_range(0, 1)) : 1'b0;
        backendRspValid    = forceRsp ||
                             (rspEn && tagQ.size() > 0 && $urandom_range(0, 99) < rspPct);
        backendRspData     = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic waitNotBusy(input bit isRead);
        int guard;
        guard = 0;
        while ((isRead ? mBusyR() : mBusyW()) && guard < 50) begin
            idle(1);
            guard++;
        end
        if (guard >= 50) begin
            nCompared++;
            nMismatched++;
            $display("FAIL busyTimeout: busy still high after %0d cycles, required low", guard);
        end
    endtask

    initial begin
        int r;
        @(negedge clk);
        idle(2);
        rst = 1'b0;
        chk("rstRdData", memReadData, '0);
        chk("rstRdSerial", memReadSerial, '0);
        chk("rstWrRspSerial", memAccessResponseSerial, '0);
        chk("rstReqAddr", backendReqAddr, '0);
        chk("rstReqWData", backendReqWData, '0);

        // Three reads, backend answers one cycle after each request.
        readyMode = 2'd1; rspEn = 1'b1; rspPct = 100;
        step(1'b1, 1'b0, 32'h100, 1'b0);
        step(1'b1, 1'b0, 32'h140, 1'b0);
        step(1'b1, 1'b0, 32'h180, 1'b0);
        idle(6);
        chk("t1NextRdSerial", nextMemReadSerial, 4'd3);

        // Fill with writes while backend stalls, then overflow attempt.
        readyMode = 2'd0; rspEn = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h400 + 32'(i * 64), 1'b0);
        chk("t2WriteBusy", memAccessWriteBusy, 1'b1);
        step(1'b0, 1'b1, 32'h500, 1'b0);
        chk("t2Err", protocolError, 1'b1);
        readyMode = 2'd1;
        idle(7);
        doReset();

        // Reach the read limit with responses held; writes still flow.
        readyMode = 2'd1; rspEn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (!mBusyR()) step(1'b1, 1'b0, 32'h800 + 32'(i * 64), 1'b0);
            else           step(1'b0, 1'b1, 32'h900 + 32'(i * 64), 1'b0);
        end
        chk("t3ReadBusy", memAccessReadBusy, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        idle(3);
        chk("t3ReadBusyCleared", memAccessReadBusy, 1'b0);
        rspEn = 1'b1;
        idle(12);

        // Alternating read/write pairs across the serial wrap.
        rspPct = 70;
        for (int p = 0; p < 20; p++) begin
            waitNotBusy(1'b1);
            step(1'b1, 1'b0, 32'h1000 + 32'(p * 64), 1'b0);
            waitNotBusy(1'b0);
            step(1'b0, 1'b1, 32'h2000 + 32'(p * 64), 1'b0);
        end
        rspPct = 100;
        idle(15);

        // Simultaneous read and write: only the write goes through.
        step(1'b1, 1'b1, 32'h200, 1'b0);
        idle(5);
        chk("t5ErrSticky", protocolError, 1'b1);
        doReset();
        chk("t5ErrCleared", protocolError, 1'b0);

        // Reset with reads in flight, then a stale response.
        rspEn = 1'b0;
        step(1'b1, 1'b0, 32'h300, 1'b0);
        step(1'b1, 1'b0, 32'h340, 1'b0);
        idle(3);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        step(1'b0, 1'b0, '0, 1'b1);
        idle(3);
        chk("t6Err", protocolError, 1'b1);
        chk("t6RdSerial", nextMemReadSerial, '0);
        chk("t6WrSerial", nextMemWriteSerial, '0);
        doReset();

        // Randomized traffic from a well-behaved core and backend.
        readyMode = 2'd2; rspEn = 1'b1; rspPct = 50;
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 3);
            if (r == 1 && !mBusyR())      step(1'b1, 1'b0, $urandom(), 1'b0);
            else if (r == 2 && !mBusyW()) step(1'b0, 1'b1, $urandom(), 1'b0);
            else                          idle(1);
        end
        readyMode = 2'd1; rspPct = 100;
        idle(30);
        chk("finalReqValid", backendReqValid, 1'b0);
        chk("finalErr", protocolError, 1'b0);
        chk("finalReadBusy", memAccessReadBusy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
